// File: rtl/pipe_pkg.sv
// Shared parameters and the in-flight tag record for the pipelined issue scheduler.
package pipe_pkg;

  localparam int unsigned N_DEF        = 10;
  localparam int unsigned NREQ_DEF     = 4;
  localparam int unsigned PIPE_LAT_DEF = 3;

  // Tag id field is sized for the default requester count.
  localparam int unsigned TAG_ID_W = $clog2(NREQ_DEF);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after ptr, cyclically.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IdW-1:0]  idx,
  output logic            any
);

  logic [IdW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      j = IdW'((32'(ptr) + off) % NREQ);
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_sched.sv
// Issues one requester's operands per cycle into a fixed-latency datapath and tags each
// operation so the returning result can be attributed to its requester.
module pipe_sched
  import pipe_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned NREQ     = NREQ_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            flush,
  input  logic [NREQ-1:0]                 req,
  input  logic [NREQ*N-1:0]               op_a,
  input  logic [NREQ*N-1:0]               op_b,
  input  logic [NREQ*N-1:0]               op_c,
  input  logic [NREQ*N-1:0]               op_d,
  output logic [NREQ-1:0]                 gnt,
  output logic [N-1:0]                    pipe_a,
  output logic [N-1:0]                    pipe_b,
  output logic [N-1:0]                    pipe_c,
  output logic [N-1:0]                    pipe_d,
  input  logic [N-1:0]                    pipe_f,
  output logic                            resp_valid,
  output logic [$clog2(NREQ)-1:0]         resp_id,
  output logic [N-1:0]                    resp_data,
  output logic [$clog2(PIPE_LAT+2)-1:0]   inflight,
  output logic                            busy
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned InfW = $clog2(PIPE_LAT + 2);

  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]    pipe_a_q, pipe_a_d, pipe_b_q, pipe_b_d;
  logic [N-1:0]    pipe_c_q, pipe_c_d, pipe_d_q, pipe_d_d;
  tag_t            tag_q [PIPE_LAT+1];
  tag_t            tag_d [PIPE_LAT+1];

  logic [NREQ-1:0] arb_gnt;
  logic [IdW-1:0]  arb_idx;
  logic            arb_any;
  logic            issue;
  logic [InfW-1:0] cnt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IdW  (IdW)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // rst_n gates the grant so it drops immediately, without waiting for an edge.
  assign issue = rst_n & en & ~flush & arb_any;
  assign gnt   = arb_gnt & {NREQ{issue}};

  always_comb begin
    ptr_d    = ptr_q;
    pipe_a_d = pipe_a_q;
    pipe_b_d = pipe_b_q;
    pipe_c_d = pipe_c_q;
    pipe_d_d = pipe_d_q;
    tag_d[0] = '0;
    if (issue) begin
      pipe_a_d = op_a[32'(arb_idx)*N +: N];
      pipe_b_d = op_b[32'(arb_idx)*N +: N];
      pipe_c_d = op_c[32'(arb_idx)*N +: N];
      pipe_d_d = op_d[32'(arb_idx)*N +: N];
      tag_d[0] = '{valid: 1'b1, id: TAG_ID_W'(arb_idx)};
      ptr_d    = (32'(arb_idx) == NREQ - 1) ? '0 : arb_idx + IdW'(1);
    end
    // The tag line never stalls; flush empties it in one edge.
    for (int unsigned k = 1; k <= PIPE_LAT; k++) begin
      tag_d[k] = flush ? '0 : tag_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      pipe_a_q <= '0;
      pipe_b_q <= '0;
      pipe_c_q <= '0;
      pipe_d_q <= '0;
      for (int unsigned k = 0; k <= PIPE_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      pipe_a_q <= pipe_a_d;
      pipe_b_q <= pipe_b_d;
      pipe_c_q <= pipe_c_d;
      pipe_d_q <= pipe_d_d;
      tag_q    <= tag_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int unsigned k = 0; k < PIPE_LAT; k++) begin
      cnt = cnt + InfW'(tag_q[k].valid);
    end
  end

  assign pipe_a     = pipe_a_q;
  assign pipe_b     = pipe_b_q;
  assign pipe_c     = pipe_c_q;
  assign pipe_d     = pipe_d_q;
  assign resp_valid = tag_q[PIPE_LAT].valid;
  assign resp_id    = IdW'(tag_q[PIPE_LAT].id);
  assign resp_data  = resp_valid ? pipe_f : '0;
  assign inflight   = cnt;
  assign busy       = (cnt != '0);

endmodule

// File: tb/tb_pipe_sched.sv
// Bench for pipe_sched: datapath stub pipe_f = pipe_a + pipe_b delayed three edges,
// a queue-based response model checked every cycle, plus directed literal checks.
module tb_pipe_sched;

  localparam int N    = 10;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic            clk = 1'b0;
  logic            rst_n, en, flush;
  logic [3:0]      req;
  logic [39:0]     op_a, op_b, op_c, op_d;
  logic [3:0]      gnt;
  logic [9:0]      pipe_a, pipe_b, pipe_c, pipe_d, pipe_f, resp_data;
  logic            resp_valid, busy;
  logic [1:0]      resp_id;
  logic [2:0]      inflight;

  pipe_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .flush      (flush),
    .req        (req),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_c       (op_c),
    .op_d       (op_d),
    .gnt        (gnt),
    .pipe_a     (pipe_a),
    .pipe_b     (pipe_b),
    .pipe_c     (pipe_c),
    .pipe_d     (pipe_d),
    .pipe_f     (pipe_f),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .inflight   (inflight),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Datapath stub: sum appears on pipe_f three edges after the operands change.
  logic [9:0] fd0, fd1, fd2;
  always @(posedge clk) begin
    fd0 <= pipe_a + pipe_b;
    fd1 <= fd0;
    fd2 <= fd1;
  end
  assign pipe_f = fd2;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int due;
    int id;
    int data;
  } ent_t;

  ent_t pend[$];
  ent_t keep[$];
  int   mptr = 0;
  int   mcyc = 0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int         g;
    logic [3:0] eg;
    int         ev, eid, ed, einf;
    if (!rst_n) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_valid", resp_valid, 0);
      chk("rst_id", resp_id, 0);
      chk("rst_data", resp_data, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_busy", busy, 0);
      pend.delete();
      mptr = 0;
      mcyc = 0;
    end else begin
      g  = (en && !flush) ? pick(req, mptr) : -1;
      eg = (g >= 0) ? 4'(1 << g) : 4'd0;
      ev = 0; eid = 0; ed = 0; einf = 0;
      foreach (pend[k]) begin
        if (pend[k].due == mcyc) begin
          ev = 1; eid = pend[k].id; ed = pend[k].data;
        end else if (pend[k].due > mcyc && pend[k].due <= mcyc + LAT) begin
          einf++;
        end
      end
      chk("m_gnt", gnt, eg);
      chk("m_valid", resp_valid, ev);
      chk("m_id", resp_id, eid);
      chk("m_data", resp_data, ed);
      chk("m_inflight", inflight, einf);
      chk("m_busy", busy, (einf != 0) ? 1 : 0);
      keep.delete();
      if (!flush) begin
        foreach (pend[k]) if (pend[k].due > mcyc) keep.push_back(pend[k]);
      end
      pend = keep;
      if (g >= 0) begin
        pend.push_back('{mcyc + LAT + 1, g,
                         (int'(op_a[g*N +: N]) + int'(op_b[g*N +: N])) % 1024});
        mptr = (g + 1) % NREQ;
      end
      mcyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    op_a[i*N +: N] = 10'(a);
    op_b[i*N +: N] = 10'(b);
    op_c[i*N +: N] = 10'(i + 7);
    op_d[i*N +: N] = 10'(i + 9);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    flush = 1'b0;
    req   = 4'hF;
    op_a = '0; op_b = '0; op_c = '0; op_d = '0;
    for (int i = 0; i < NREQ; i++) set_op(i, i * 100 + 1, i + 5);
    #2;
    chk("reset_gnt", gnt, 0);
    chk("reset_pipe_a", pipe_a, 0);
    chk("reset_valid", resp_valid, 0);
    chk("reset_inflight", inflight, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All requesters held: strict rotation, back-to-back responses.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rr_gnt", gnt, 1 << (c % 4));
      if (c == 3) chk("rr_inflight", inflight, 3);
      if (c >= 4) begin
        chk("rr_resp_valid", resp_valid, 1);
        chk("rr_resp_id", resp_id, (c - 4) % 4);
      end
      nxt();
    end
    req = 4'h0;
    repeat (4) nxt();

    // Enable gating; ptr is back at 0.
    en  = 1'b0;
    req = 4'b0101;
    @(negedge clk);
    chk("en0_gnt", gnt, 0);
    nxt();
    en = 1'b1;
    @(negedge clk);
    chk("en1_gnt", gnt, 4'b0001);
    chk("en0_pipe_a_held", pipe_a, 301);
    nxt();
    req = 4'b0100;
    @(negedge clk);
    chk("en1_gnt2", gnt, 4'b0100);
    nxt();
    req = 4'h0;
    repeat (4) nxt();

    // Single op: 10 + 12 returns four cycles later.
    set_op(0, 10, 12);
    req = 4'b0001;
    @(negedge clk);
    chk("single_gnt", gnt, 4'b0001);
    nxt();
    req = 4'h0;
    repeat (3) nxt();
    @(negedge clk);
    chk("single_valid", resp_valid, 1);
    chk("single_id", resp_id, 0);
    chk("single_data", resp_data, 22);
    nxt();
    repeat (2) nxt();

    // Wrap: (1000 + 100) mod 1024 = 76.
    set_op(1, 1000, 100);
    req = 4'b0010;
    @(negedge clk);
    chk("wrap_gnt", gnt, 4'b0010);
    nxt();
    req = 4'h0;
    repeat (3) nxt();
    @(negedge clk);
    chk("wrap_id", resp_id, 1);
    chk("wrap_data", resp_data, 76);
    nxt();

    // Three issues then flush: nothing returns.
    req = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) chk("fl_inflight_pre", inflight, 2);
      nxt();
    end
    flush = 1'b1;
    @(negedge clk);
    chk("fl_gnt", gnt, 0);
    nxt();
    flush = 1'b0;
    req   = 4'h0;
    for (int c = 4; c < 7; c++) begin
      @(negedge clk);
      chk("fl_no_resp", resp_valid, 0);
      if (c == 4) chk("fl_inflight", inflight, 0);
      nxt();
    end

    // Asynchronous reset with two operations in flight.
    req = 4'b0011;
    nxt();
    req = 4'b0001;
    nxt();
    req = 4'b1100;
    chk("ar_inflight_pre", inflight, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", gnt, 0);
    chk("ar_valid", resp_valid, 0);
    chk("ar_inflight", inflight, 0);
    chk("ar_busy", busy, 0);
    chk("ar_pipe_a", pipe_a, 0);
    chk("ar_data", resp_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b1000;
    @(negedge clk);
    chk("ar_post_gnt", gnt, 4'b1000);
    nxt();
    req = 4'h0;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      chk("ar_no_resp", resp_valid, 0);
      nxt();
    end
    @(negedge clk);
    chk("ar_new_resp_id", resp_id, 3);
    nxt();
    repeat (2) nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
